timer_bank: RTL

TIMER_BANK -- requirements
Module: timer_bank

---
 rtl/timer_bank_pkg.sv | 23 ++
 rtl/timer_bank_ch.sv | 92 +++++++++
 rtl/timer_bank.sv | 100 ++++++++++
 3 files changed

// File: rtl/timer_bank_pkg.sv
// Shared types and address map for the timer bank.
// Optional feature macro: TIMER_BANK_PRESCALER_EN (global tick prescaler).
package timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } ch_state_t;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam logic [5:0] ADDR_PRESCALE = 6'h3C;
  localparam int         PRESCALE_W    = 16;

endpackage

// File: rtl/timer_bank_ch.sv
// One timer channel: CTRL/PRESET/COUNT/pending registers and its sequencing FSM.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | stopped, waiting for EN
//   LOAD    | copy PRESET into COUNT
//   CNT     | decrement COUNT on each tick; reaching 0 moves to INT
//   INT     | one cycle: set pending, then reload or stop (one-shot)
module timer_bank_ch
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             ctrl_we,
  input  logic             preset_we,
  input  logic             status_we,
  input  logic [CNT_W-1:0] wdata,
  output logic             en,
  output logic [1:0]       mode,
  output logic             im,
  output logic [CNT_W-1:0] preset,
  output logic [CNT_W-1:0] count,
  output logic             pending
);

  ch_state_t state;
  logic      stop;

  // A CTRL write clearing EN freezes the channel on that edge so COUNT keeps
  // the value software saw; the FSM drops to IDLE on the following edge.
  assign stop = ctrl_we & ~wdata[0];

  // Register writes and the channel FSM; pending set is placed after the
  // clear so a coinciding set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      en      <= 1'b0;
      mode    <= MODE_ONESHOT;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (status_we && wdata[0]) pending <= 1'b0;

      if (!stop) begin
        case (state)
          ST_IDLE: if (en) state <= ST_LOAD;
          ST_LOAD: begin
            if (!en) state <= ST_IDLE;
            else begin
              count <= preset;
              state <= ST_CNT;
            end
          end
          ST_CNT: begin
            if (!en) state <= ST_IDLE;
            else if (count == '0) state <= ST_INT;
            else if (tick) begin
              count <= count - CNT_W'(1);
              if (count == CNT_W'(1)) state <= ST_INT;
            end
          end
          ST_INT: begin
            if (!en) state <= ST_IDLE;
            else begin
              pending <= 1'b1;
              if (mode == MODE_RELOAD) state <= ST_LOAD;
              else begin
                en    <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      if (ctrl_we) begin
        en   <= wdata[0];
        mode <= wdata[2:1];
        im   <= wdata[3];
      end
      if (preset_we) preset <= wdata;
    end
  end

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH down-counting timers behind a word-addressed register map.
// Optional feature macro: TIMER_BANK_PRESCALER_EN adds a 16-bit PRESCALE
// register at word 0x3C that slows CNT decrements; otherwise ticks are
// every cycle and word 0x3C reads 0.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        addr,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [3:0]       ch_idx;
  logic [1:0]       off;
  logic             tick;
  logic [NUM_CH-1:0] en_v;
  logic [NUM_CH-1:0] im_v;
  logic [NUM_CH-1:0] pend_v;
  logic [1:0]       mode_v   [NUM_CH];
  logic [CNT_W-1:0] preset_v [NUM_CH];
  logic [CNT_W-1:0] count_v  [NUM_CH];

  assign ch_idx = addr[5:2];
  assign off    = addr[1:0];

`ifdef TIMER_BANK_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] pre_cnt;

  // Using >= keeps the counter from running the full 16-bit wrap when
  // PRESCALE is lowered below the current count.
  assign tick = (pre_cnt >= prescale);

  // PRESCALE register and the shared prescale counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (we && addr == ADDR_PRESCALE) prescale <= din[PRESCALE_W-1:0];
      if (tick) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + PRESCALE_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = we && (ch_idx == 4'(i));

    timer_bank_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .ctrl_we   (sel && off == OFF_CTRL),
      .preset_we (sel && off == OFF_PRESET),
      .status_we (sel && off == OFF_STATUS),
      .wdata     (din[CNT_W-1:0]),
      .en        (en_v[i]),
      .mode      (mode_v[i]),
      .im        (im_v[i]),
      .preset    (preset_v[i]),
      .count     (count_v[i]),
      .pending   (pend_v[i])
    );
  end

  // Read mux: unmapped words, including channels beyond NUM_CH, read 0.
  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == 4'(i)) begin
        case (off)
          OFF_CTRL:   dout = {28'b0, im_v[i], mode_v[i], en_v[i]};
          OFF_PRESET: dout = 32'(preset_v[i]);
          OFF_COUNT:  dout = 32'(count_v[i]);
          OFF_STATUS: dout = {31'b0, pend_v[i]};
          default:    dout = '0;
        endcase
      end
    end
`ifdef TIMER_BANK_PRESCALER_EN
    if (addr == ADDR_PRESCALE) dout = {{(32-PRESCALE_W){1'b0}}, prescale};
`endif
  end

  assign irq     = pend_v & im_v;
  assign irq_any = |irq;

endmodule
